// File: rtl/pixel_fifo_writer_if.sv
// Pixel stream input and async-FIFO write port of the pixel FIFO writer.
interface pixel_fifo_writer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH+1:0] fifo_wr_data;

    // Environment side: drives pixels and the FIFO full flag.
    modport master (
        output in_valid,
        output in_data,
        output fifo_full,
        input  in_ready,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

    // Writer side: consumes pixels, writes tagged words into the FIFO.
    modport slave (
        input  in_valid,
        input  in_data,
        input  fifo_full,
        output in_ready,
        output fifo_wr_en,
        output fifo_wr_data
    );
endinterface

// File: rtl/pixel_fifo_writer.sv
// Write-side producer for the pixel CDC FIFO: tracks raster position, tags
// {sof, eol, pixel} and writes through a 2-entry skid buffer so in_ready stays
// registered and independent of fifo_full.
module pixel_fifo_writer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 32,
    parameter int unsigned IMG_HEIGHT = 32,
    parameter int unsigned X_W        = 5,
    parameter int unsigned Y_W        = 5
) (
    input  logic                wr_clk,
    input  logic                wr_rst_n,
    input  logic                enable,
    pixel_fifo_writer_if.slave  bus,
    output logic                frame_done,
    output logic [15:0]         frame_cnt,
    output logic                busy
);

    localparam int unsigned WORD_W = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic                head_valid;
    logic                skid_valid;
    logic                head_valid_nxt;
    logic                skid_valid_nxt;
    logic [WORD_W-1:0]   head_q;
    logic [WORD_W-1:0]   skid_q;
    logic                accept;
    logic                wr;
    logic                x_last;
    logic                y_last;
    logic                frame_last;
    logic                sof;
    logic                eol;
    logic [WORD_W-1:0]   word_c;

    assign accept     = bus.in_valid && bus.in_ready;
    assign wr         = head_valid && !bus.fifo_full;
    assign x_last     = (x_q == X_W'(IMG_WIDTH - 1));
    assign y_last     = (y_q == Y_W'(IMG_HEIGHT - 1));
    assign frame_last = x_last && y_last;
    assign sof        = (x_q == '0) && (y_q == '0);
    assign eol        = x_last;
    assign word_c     = {sof, eol, bus.in_data};

    // The FIFO sees the head entry directly; a write happens whenever it is valid and not full.
    assign bus.fifo_wr_en   = wr;
    assign bus.fifo_wr_data = head_q;

    // State register.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state: enable only matters at a frame boundary; DRAIN waits for an empty buffer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = ACTIVE;
            ACTIVE:  if (accept && frame_last && !enable) state_nxt = DRAIN;
            DRAIN:   if (!head_valid && !skid_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer occupancy: a write frees head (refilled from skid or the new pixel), else an accept fills the first free slot.
    always_comb begin
        head_valid_nxt = head_valid;
        skid_valid_nxt = skid_valid;
        if (wr) begin
            if (skid_valid) begin
                head_valid_nxt = 1'b1;
                skid_valid_nxt = accept;
            end else begin
                head_valid_nxt = accept;
            end
        end else if (accept) begin
            if (!head_valid) head_valid_nxt = 1'b1;
            else             skid_valid_nxt = 1'b1;
        end
    end

    // Buffer storage, kept in acceptance order.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            head_valid <= head_valid_nxt;
            skid_valid <= skid_valid_nxt;
            if (wr) begin
                if (skid_valid) begin
                    head_q <= skid_q;
                    if (accept) skid_q <= word_c;
                end else if (accept) begin
                    head_q <= word_c;
                end
            end else if (accept) begin
                if (!head_valid) head_q <= word_c;
                else             skid_q <= word_c;
            end
        end
    end

    // Raster position and frame accounting.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= accept && frame_last;
            if (accept) begin
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_last ? '0 : y_q + Y_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
                if (frame_last) frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Registered handshake and status: ready only while framing with a free skid slot.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            bus.in_ready <= (state_nxt == ACTIVE) && !skid_valid_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_pixel_fifo_writer.sv
// Scoreboard bench for pixel_fifo_writer with a 4x2 image.
module tb_pixel_fifo_writer;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 4;
    localparam int unsigned IH = 2;

    logic          wr_clk   = 1'b0;
    logic          wr_rst_n = 1'b0;
    logic          enable   = 1'b0;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic          busy;

    pixel_fifo_writer_if #(.DATA_WIDTH(DW)) bus ();

    pixel_fifo_writer #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .X_W        (5),
        .Y_W        (5)
    ) dut (
        .wr_clk     (wr_clk),
        .wr_rst_n   (wr_rst_n),
        .enable     (enable),
        .bus        (bus.slave),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 wr_clk = ~wr_clk;

    logic [DW+1:0] exp_q[$];
    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int fd_due   = -1;
    int mx       = 0;
    int my       = 0;
    int sof_seen = 0;
    bit rnd_on   = 1'b0;

    always @(posedge wr_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference raster model: called when a pixel is seen accepted.
    task automatic note_accept(input logic [DW-1:0] d);
        logic s, e;
        s = (mx == 0) && (my == 0);
        e = (mx == IW - 1);
        exp_q.push_back({s, e, d});
        if (e) begin
            if (my == IH - 1) fd_due = cyc + 1;
            mx = 0;
            my = (my == IH - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send_pixel(input logic [DW-1:0] d);
        int budget;
        budget = 300;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge wr_clk);
            if (bus.in_ready) begin
                note_accept(d);
                tick();
                break;
            end
            budget--;
            if (budget == 0) begin
                fail_now("send_timeout");
                tick();
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        repeat (2) tick();
    endtask

    // Monitor: pops the scoreboard on every FIFO write and checks frame_done timing.
    always @(negedge wr_clk) begin
        if (wr_rst_n) begin
            if (bus.fifo_full) check("no_write_while_full", 32'(bus.fifo_wr_en), 32'd0);
            if (bus.fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write (t=%0t)",
                             bus.fifo_wr_data, $time);
                end else begin
                    logic [DW+1:0] w;
                    w = exp_q.pop_front();
                    check("fifo_word", 32'(bus.fifo_wr_data), 32'(w));
                    if (w[DW+1]) sof_seen++;
                end
            end
            if (frame_done || (cyc == fd_due))
                check("frame_done", 32'(frame_done), 32'(cyc == fd_due));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, acc, sof0;
        logic [DW-1:0] d;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.fifo_full = 1'b0;

        // Reset values.
        repeat (3) tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("rst_wr_data", 32'(bus.fifo_wr_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        wr_rst_n = 1'b1;

        // 1: disabled, upstream valid -> nothing happens.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (10) begin
            @(negedge wr_clk);
            check("t1_in_ready", 32'(bus.in_ready), 32'd0);
            check("t1_wr_en", 32'(bus.fifo_wr_en), 32'd0);
            check("t1_busy", 32'(busy), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;

        // 2: one frame at full rate.
        enable = 1'b1;
        tick();
        check("t2_in_ready", 32'(bus.in_ready), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        t0 = cyc;
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h10 + i));
        check("t2_throughput_cycles", 32'(cyc - t0), 32'd8);
        wait_drain();
        check("t2_frame_cnt", 32'(frame_cnt), 32'd1);

        // 3: FIFO full for 6 cycles starting with an empty buffer.
        for (int i = 0; i < 3; i++) send_pixel(8'(8'h20 + i));
        repeat (3) tick();
        bus.fifo_full = 1'b1;
        bus.in_valid  = 1'b1;
        d   = 8'h23;
        acc = 0;
        bus.in_data = d;
        repeat (6) begin
            @(negedge wr_clk);
            if (bus.in_ready) begin
                note_accept(d);
                acc++;
                d = d + 8'd1;
            end
            tick();
            bus.in_data = d;
        end
        bus.in_valid = 1'b0;
        check("t3_accepts_while_full", 32'(acc), 32'd2);
        check("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
        bus.fifo_full = 1'b0;
        @(negedge wr_clk);
        check("t3_release_write", 32'(bus.fifo_wr_en), 32'd1);
        check("t3_release_ready_lag", 32'(bus.in_ready), 32'd0);
        tick();
        check("t3_ready_back", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) send_pixel(8'(8'h25 + i));
        wait_drain();
        check("t3_frame_cnt", 32'(frame_cnt), 32'd2);

        // 4: enable dropped mid-frame; frame still completes, then DRAIN -> IDLE.
        for (int i = 0; i < 3; i++) send_pixel(8'(8'h30 + i));
        enable = 1'b0;
        for (int i = 0; i < 5; i++) send_pixel(8'(8'h33 + i));
        check("t4_ready_after_frame", 32'(bus.in_ready), 32'd0);
        check("t4_busy_draining", 32'(busy), 32'd1);
        wait_drain();
        check("t4_busy_idle", 32'(busy), 32'd0);
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge wr_clk);
            check("t4_idle_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("t4_frame_cnt", 32'(frame_cnt), 32'd3);

        // 5: three frames back to back with random back-pressure.
        enable = 1'b1;
        tick();
        sof0   = sof_seen;
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    bus.fifo_full = ($urandom_range(0, 2) == 0);
                    tick();
                end
                bus.fifo_full = 1'b0;
            end
        join_none
        for (int i = 0; i < 24; i++) send_pixel(8'(8'h40 + i));
        rnd_on = 1'b0;
        tick();
        bus.fifo_full = 1'b0;
        wait_drain();
        check("t5_sof_count", 32'(sof_seen - sof0), 32'd3);
        check("t5_frame_cnt", 32'(frame_cnt), 32'd6);

        // 5b: frame counter wraps from 0xFFFF.
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h50 + i));
        wait_drain();
        check("t5_frame_cnt_wrap", 32'(frame_cnt), 32'd0);

        // 6: reset with two pixels buffered at x=2.
        bus.fifo_full = 1'b1;
        send_pixel(8'h60);
        send_pixel(8'h61);
        check("t6_pre_busy", 32'(busy), 32'd1);
        #3;
        wr_rst_n = 1'b0;
        #1;
        check("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("t6_rst_wr_data", 32'(bus.fifo_wr_data), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_frame_done", 32'(frame_done), 32'd0);
        check("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        exp_q.delete();
        mx     = 0;
        my     = 0;
        fd_due = -1;
        bus.fifo_full = 1'b0;
        #1;
        check("t6_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        tick();
        wr_rst_n = 1'b1;
        repeat (3) tick();
        sof0 = sof_seen;
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h70 + i));
        wait_drain();
        check("t6_sof_count", 32'(sof_seen - sof0), 32'd1);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
